// File: rtl/pad_pkg.sv
// Shared types and constants for the NES pad reader.
// Button positions match the order bits arrive on the serial link.
package pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } pad_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int NUM_BUTTONS = 8;

endpackage

// File: rtl/pad_if.sv
// Pad reader bundle: controller wire link plus the CPU-side button vector.
// master = reader, slave = controller/CPU side (or a testbench).
interface pad_if;

  logic       enable;
  logic       pad_data_in;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       buttons_valid;

  modport master (
    input  enable,
    input  pad_data_in,
    output pad_latch,
    output pad_clk,
    output buttons,
    output buttons_valid
  );

  modport slave (
    output enable,
    output pad_data_in,
    input  pad_latch,
    input  pad_clk,
    input  buttons,
    input  buttons_valid
  );

endinterface

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the asynchronous pad data line.
// Resets to 1 so an unscanned line reads as "released".
module pad_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pad_reader.sv
// Periodic NES/SNES controller scanner producing an atomically updated button vector.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | latch low, clock high; wait for poll counter wrap with enable
//  LATCH  | latch high for two ticks, then sample bit 0
//  CLK_LO | shift clock low for one tick
//  CLK_HI | shift clock high for one tick, sample bit at end of tick
//  DONE   | publish inverted shift register, pulse buttons_valid
module pad_reader
  import pad_pkg::*;
#(
  parameter int TICK_DIV = 128,
  parameter int POLL_DIV = 65536,
  parameter int NUM_BITS = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  pad_if.master  bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int POLL_W = $clog2(POLL_DIV);
  localparam int IDX_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BITS - 1);

  pad_state_t          state;
  pad_state_t          state_next;
  logic [TICK_W-1:0]   tick_cnt;
  logic [POLL_W-1:0]   poll_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic                latch_second;
  logic [NUM_BITS-1:0] shift;
  logic                data_sync;
  logic                tick_end;
  logic                scanning;

  logic [7:0]          buttons_q;
  logic                valid_q;
  logic                latch_q;
  logic                pclk_q;

  pad_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.pad_data_in),
    .q       (data_sync)
  );

  assign tick_end = (tick_cnt == TICK_LAST);
  assign scanning = (state == LATCH) || (state == CLK_LO) || (state == CLK_HI);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.enable && (poll_cnt == '0)) state_next = LATCH;
      end
      LATCH: begin
        if (tick_end && latch_second) state_next = (NUM_BITS == 1) ? DONE : CLK_LO;
      end
      CLK_LO: begin
        if (tick_end) state_next = CLK_HI;
      end
      CLK_HI: begin
        if (tick_end) state_next = (bit_idx == IDX_LAST) ? DONE : CLK_LO;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt     <= '0;
      poll_cnt     <= '0;
      bit_idx      <= '0;
      latch_second <= 1'b0;
      shift        <= '1;
      buttons_q    <= 8'h00;
      valid_q      <= 1'b0;
      latch_q      <= 1'b0;
      pclk_q       <= 1'b1;
    end else begin
      if (!bus.enable)               poll_cnt <= '0;
      else if (poll_cnt == POLL_LAST) poll_cnt <= '0;
      else                            poll_cnt <= poll_cnt + 1'b1;

      if (scanning && !tick_end) tick_cnt <= tick_cnt + 1'b1;
      else                       tick_cnt <= '0;

      // Pad pins are registered from next state so they never glitch on decode.
      latch_q <= (state_next == LATCH);
      pclk_q  <= (state_next != CLK_LO);

      valid_q <= (state == DONE);
      if (state == DONE) buttons_q <= ~shift[7:0];

      case (state)
        IDLE: begin
          bit_idx      <= '0;
          latch_second <= 1'b0;
        end
        LATCH: begin
          if (tick_end) begin
            latch_second <= 1'b1;
            if (latch_second) begin
              shift[0] <= data_sync;
              bit_idx  <= IDX_W'(1);
            end
          end
        end
        CLK_HI: begin
          if (tick_end) begin
            shift[bit_idx] <= data_sync;
            bit_idx        <= bit_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.buttons       = buttons_q;
  assign bus.buttons_valid = valid_q;
  assign bus.pad_latch     = latch_q;
  assign bus.pad_clk       = pclk_q;

endmodule

// File: tb/tb_pad_reader.sv
// Bench for pad_reader: behavioural 4021 pad model, scoreboard on buttons_valid,
// and a timing monitor for latch/clock waveform shape and scan period.
module tb_pad_reader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pad_if pif ();

  pad_reader #(
    .TICK_DIV (4),
    .POLL_DIV (100),
    .NUM_BITS (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (pif)
  );

  int tests = 0;
  int fails = 0;

  // 4021 model: parallel load while latch high, shift toward Q8 on pad_clk rise.
  logic [7:0] wire_pat = 8'hFF;
  logic       connected = 1'b1;
  logic [7:0] sr = 8'hFF;
  logic       pclk_prev = 1'b1;

  always @(posedge clk) begin
    pclk_prev <= pif.pad_clk;
    if (pif.pad_latch)                  sr <= wire_pat;
    else if (pif.pad_clk && !pclk_prev) sr <= {1'b1, sr[7:1]};
  end

  assign pif.pad_data_in = connected ? sr[0] : 1'b1;

  logic [7:0] exp_q[$];
  logic [7:0] last_btn = 8'h00;

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && pif.buttons_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: buttons=%h with no scan expected", pif.buttons);
        end else begin
          e = exp_q.pop_front();
          if (pif.buttons !== e) begin
            fails++;
            $display("FAIL scan_result: buttons=%h expected %h", pif.buttons, e);
          end
        end
      end
      if (reset_n && !pif.buttons_valid && (pif.buttons !== last_btn)) begin
        tests++;
        fails++;
        $display("FAIL atomic_update: buttons changed %h -> %h without valid", last_btn, pif.buttons);
      end
      last_btn = pif.buttons;
    end
  end

  int   cyc = 0;
  int   n_rise = 0;
  int   rise_cyc = 0;
  int   prev_rise_cyc = 0;
  int   latch_run = 0;
  int   latch_len = 0;
  int   lo_pulses = 0;
  int   low_run = 0;
  int   bad_width = 0;
  int   n_valid = 0;
  int   valid_cyc = 0;
  logic latch_prev = 1'b0;
  logic pclk_prev_m = 1'b1;
  logic valid_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (pif.pad_latch && !latch_prev) begin
        prev_rise_cyc = rise_cyc;
        rise_cyc      = cyc;
        n_rise++;
        lo_pulses = 0;
        latch_run = 0;
      end
      if (pif.pad_latch) latch_run++;
      else if (latch_prev) latch_len = latch_run;
      if (!pif.pad_clk) low_run++;
      else if (!pclk_prev_m) begin
        lo_pulses++;
        if (low_run != 4) bad_width++;
        low_run = 0;
      end
      if (pif.buttons_valid) begin
        if (valid_prev) begin
          tests++;
          fails++;
          $display("FAIL valid_width: buttons_valid high for more than one cycle at cycle %0d", cyc);
        end
        n_valid++;
        valid_cyc = cyc;
      end
      latch_prev  = pif.pad_latch;
      pclk_prev_m = pif.pad_clk;
      valid_prev  = pif.buttons_valid;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valids(input int n, input int budget, input string name);
    int target;
    int k;
    target = n_valid + n;
    k = 0;
    while (n_valid < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_valid < target) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, %0d of %0d valid pulses after %0d cycles", name, n - (target - n_valid), n, budget);
    end
  endtask

  task automatic wait_scan_pulse(input int r0, input int pulses, input logic pclk_level, input string name);
    int k;
    k = 0;
    while (!(n_rise > r0 && lo_pulses == pulses && pif.pad_clk == pclk_level) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, (k < 300) ? 1 : 0, 1);
  endtask

  initial begin
    int r0;
    int v0;
    pif.enable = 1'b1;
    connected  = 1'b1;
    wire_pat   = 8'hF6;          // A and Start pressed (wire 0,1,1,0,1,1,1,1)
    reset_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_latch",   pif.pad_latch,     0);
    check("reset_pad_clk", pif.pad_clk,       1);
    check("reset_buttons", pif.buttons,       0);
    check("reset_valid",   pif.buttons_valid, 0);

    exp_q.push_back(8'h09);
    reset_n = 1'b1;
    wait_valids(1, 200, "scan1");
    check("latch_high_cycles", latch_len, 8);
    check("pad_clk_pulses",    lo_pulses, 7);
    check("pad_clk_low_width_errors", bad_width, 0);
    check("scan_length", valid_cyc - rise_cyc, 65);

    wire_pat = 8'h7F;            // Right only
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h80);
    wait_valids(1, 200, "periodic1");
    check("poll_period_1", rise_cyc - prev_rise_cyc, 100);
    wait_valids(1, 200, "periodic2");
    check("poll_period_2", rise_cyc - prev_rise_cyc, 100);

    wire_pat = 8'hED;            // B and Up
    exp_q.push_back(8'h12);
    r0 = n_rise;
    wait_scan_pulse(r0, 3, 1'b1, "reach_clk_hi_bit3");
    pif.enable = 1'b0;
    wait_valids(1, 200, "scan_after_disable");
    v0 = n_valid;
    r0 = n_rise;
    repeat (500) @(negedge clk);
    check("no_latch_while_disabled", n_rise, r0);
    check("no_valid_while_disabled", n_valid, v0);
    exp_q.push_back(8'h12);
    pif.enable = 1'b1;
    @(negedge clk);
    check("latch_on_enable", pif.pad_latch, 1);
    wait_valids(1, 200, "scan_after_enable");

    wire_pat = 8'hBE;            // A and Left
    r0 = n_rise;
    v0 = n_valid;
    wait_scan_pulse(r0, 4, 1'b0, "reach_clk_lo_bit5");
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_latch",   pif.pad_latch,     0);
    check("midreset_pad_clk", pif.pad_clk,       1);
    check("midreset_buttons", pif.buttons,       0);
    check("midreset_valid",   pif.buttons_valid, 0);
    check("midreset_no_valid", n_valid, v0);
    exp_q.push_back(8'h41);
    reset_n = 1'b1;
    wait_valids(1, 200, "scan_after_reset");

    connected = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    wait_valids(2, 300, "disconnected");
    check("disconnected_period", rise_cyc - prev_rise_cyc, 100);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
